spart_baud_gen: RTL
===================

SPART_BAUD_GEN -- requirements
Module: spart_baud_gen

Interface
REQ-001 The block SHALL declare parameter DEFAULT_DIV, default 16'd325, reset value of the divisor (50 MHz / (9600 x 16) - 1).
REQ-002 The block SHALL declare parameter OVERSAMPLE, default 16, number of rxenable pulses per txenable pulse; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port iocs, input, 1, I/O chip select.
REQ-006 The block SHALL have port iorw, input, 1, 1 = read, 0 = write.
REQ-007 The block SHALL have port ioaddr, input, 2, register select.
REQ-008 The block SHALL have port databus, input, 8, write data from the bus interface.
REQ-009 The block SHALL have port rxenable, output, 1, one-cycle oversample tick to the receive stage.
REQ-010 The block SHALL have port txenable, output, 1, one-cycle bit tick to the transmit stage.

Function
REQ-011 The block SHALL hold a 16-bit divisor register div, a 16-bit down-counter cnt and a log2(OVERSAMPLE)-bit tick counter os_cnt.
REQ-012 When iocs=1, iorw=0 and ioaddr=2'b10, the block SHALL write databus into div[7:0] at the clock edge.
REQ-013 When iocs=1, iorw=0 and ioaddr=2'b11, the block SHALL write databus into div[15:8] at the clock edge.
REQ-014 The block SHALL ignore writes to ioaddr 2'b00 and 2'b01, all reads, and any cycle with iocs=0; div is unchanged in those cycles.
REQ-015 Each cycle with cnt != 0, the block SHALL set cnt <= cnt - 1 and drive rxenable=0 in the next cycle.
REQ-016 Each cycle with cnt == 0, the block SHALL set cnt <= div and rxenable <= 1, so that the rxenable period is div+1 clocks.
REQ-017 With div = 0, the block SHALL assert rxenable in every cycle.
REQ-018 On each rxenable pulse, the block SHALL increment os_cnt, wrapping from OVERSAMPLE-1 to 0.
REQ-019 The block SHALL assert txenable in the same cycle as the rxenable pulse that wraps os_cnt, giving exactly one txenable per OVERSAMPLE rxenable pulses.
REQ-020 rxenable and txenable SHALL be registered outputs, each high for exactly one clock per event.
REQ-021 When the divisor is rewritten mid-count, the block SHALL let the current count finish and reload the new div at the next terminal count.
REQ-022 Writing only one byte SHALL take effect by itself; the block SHALL NOT interlock between the low and high byte writes.

Reset
REQ-023 While rst=1, the block SHALL force, asynchronously, div=DEFAULT_DIV, cnt=DEFAULT_DIV, os_cnt=0, rxenable=0 and txenable=0.
REQ-024 Reset SHALL abort any count in progress.
REQ-025 After rst deasserts, the first rxenable SHALL occur DEFAULT_DIV+1 cycles later.

Configuration
REQ-026 When BRG_RESTART_ON_LOAD_EN is defined, a write to ioaddr 2'b11 SHALL also load cnt with the new {databus, div[7:0]} and clear os_cnt in the same edge, giving immediate restart.
REQ-027 When BRG_RESTART_ON_LOAD_EN is undefined, the block SHALL apply REQ-021 only: no counter restart on write.

Verification
REQ-028 The bench SHALL cover: rst pulse, no writes -> rxenable every 326 clocks, txenable every 5216 clocks, first rxenable 326 clocks after rst release.
REQ-029 The bench SHALL cover: write 8'h0A at addr 2'b10 and 8'h00 at 2'b11 -> after the current count completes, rxenable every 11 clocks, txenable every 176 clocks.
REQ-030 The bench SHALL cover: div=0 -> rxenable constantly 1, txenable high once every 16 clocks.
REQ-031 The bench SHALL cover: writes at 2'b00/2'b01, a read at 2'b10, and iocs=0 with ioaddr=2'b10 -> div unchanged, period unchanged.
REQ-032 The bench SHALL cover: rst asserted mid-count with cnt=100 and os_cnt=7 -> outputs 0 immediately without a clock edge, counters restored to defaults.
REQ-033 The bench SHALL cover, with BRG_RESTART_ON_LOAD_EN: high-byte write of 8'h01 when div[7:0]=8'h00 -> next rxenable exactly 257 clocks after the write edge; without the macro -> after the old count expires plus 257.

Source files
------------

// File: rtl/spart_baud_gen.sv
// Baud-rate generator: programmable divisor producing rxenable oversample ticks and txenable bit ticks.
// Optional BRG_RESTART_ON_LOAD_EN: a high-byte divisor write restarts the counters immediately.
module spart_baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = 16'd325,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  output logic       rxenable,
  output logic       txenable
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             rx_q, rx_d;
  logic             tx_q, tx_d;
  logic             wr_lo, wr_hi, tick, os_wrap;

  // Next-state: divisor writes, terminal-count reload, oversample tick counting
  always_comb begin
    wr_lo    = iocs && !iorw && (ioaddr == 2'b10);
    wr_hi    = iocs && !iorw && (ioaddr == 2'b11);
    tick     = (cnt_q == '0);
    os_wrap  = (os_cnt_q == OS_W'(OVERSAMPLE - 1));

    div_d    = div_q;
    cnt_d    = cnt_q - DIV_W'(1);
    os_cnt_d = os_cnt_q;
    rx_d     = 1'b0;
    tx_d     = 1'b0;

    if (wr_lo) div_d[7:0]  = databus;
    if (wr_hi) div_d[15:8] = databus;

    // Reload uses the divisor held before this edge, so a rewrite lands on the next terminal count
    if (tick) begin
      cnt_d    = div_q;
      rx_d     = 1'b1;
      os_cnt_d = os_cnt_q + OS_W'(1);
      tx_d     = os_wrap;
    end

`ifdef BRG_RESTART_ON_LOAD_EN
    if (wr_hi) begin
      cnt_d    = {databus, div_q[7:0]};
      os_cnt_d = '0;
      rx_d     = 1'b0;
      tx_d     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= DEFAULT_DIV;
      cnt_q    <= DEFAULT_DIV;
      os_cnt_q <= '0;
      rx_q     <= 1'b0;
      tx_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      os_cnt_q <= os_cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
    end
  end

  assign rxenable = rx_q;
  assign txenable = tx_q;

endmodule
